dm_access_ctrl: RTL

Sequencer between the pipeline's MEM stage and a single-port, word-wide data memory with a ready handshake. It turns each load/store into word transactions: one read, one write, or a read-modify-write for `sb`/`sh`. It sign/zero-extends load data, flags misaligned accesses, and stalls the pipeline until the access completes.

---
 rtl/dm_access_ctrl_pkg.sv | 53 +++++
 rtl/dm_access_ctrl_lane_mux.sv | 64 ++++++
 rtl/dm_access_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access sequencer.
//
// Contents:
//   DM_*        - dm_type encodings from the decoder (word/half/byte, signed/unsigned)
//   dm_state_e  - sequencer FSM state codes
//   dm_size_e   - access width after decoding dm_type
//   dm_size     - dm_type -> access width; reserved codes 101..111 decode as word
//   dm_is_signed- whether a sub-word load sign-extends
//   dm_misaligned - alignment check for a given width and byte offset
package dm_access_ctrl_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_RESP   = 3'd4
  } dm_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } dm_size_e;

  function automatic dm_size_e dm_size(input logic [2:0] t);
    case (t)
      DM_WORD:            return SZ_WORD;
      DM_HALF, DM_HALF_U: return SZ_HALF;
      DM_BYTE, DM_BYTE_U: return SZ_BYTE;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_is_signed(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_BYTE);
  endfunction

  function automatic logic dm_misaligned(input dm_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_HALF: return a[0];
      SZ_BYTE: return 1'b0;
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_ctrl_lane_mux.sv
// Combinational lane mux for the data-memory sequencer.
// Extracts and extends the addressed lane of a memory word for loads, and
// merges store data into the addressed lane of a memory word for sb/sh.
//
// Ports:
//   word     in  32 - memory word (read data)
//   addr_lo  in  2  - byte offset within the word
//   dm_type  in  3  - access type encoding
//   wdata    in  32 - store data, right-justified
//   load_val out 32 - extracted, sign/zero-extended load result
//   merged   out 32 - word with the store lane replaced (wdata for word stores)
module dm_access_ctrl_lane_mux
  import dm_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_type,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  function automatic logic [31:0] ext_byte(input logic signed [7:0] b, input logic sgn);
    logic signed [31:0] s;
    s = 32'(b);
    return sgn ? s : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic signed [15:0] h, input logic sgn);
    logic signed [31:0] s;
    s = 32'(h);
    return sgn ? s : {16'b0, h};
  endfunction

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;
  logic               sgn;

  assign byte_lane = word[{addr_lo, 3'b000} +: 8];
  assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];
  assign sgn       = dm_is_signed(dm_type);

  always_comb begin
    load_val = word;
    merged   = wdata;
    case (dm_size(dm_type))
      SZ_BYTE: begin
        load_val = ext_byte(byte_lane, sgn);
        merged   = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = ext_half(half_lane, sgn);
        merged   = word;
        merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer between the MEM stage and a single-port,
// word-wide memory with a ready handshake. Loads and sw become one memory
// transaction; sb/sh become a read-modify-write. Misaligned accesses are
// answered immediately with err and never reach memory. The pipeline is
// stalled until the one-cycle done pulse.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req, we, dm_type    - MEM-stage request, store flag, access type
//   addr, wdata         - byte address, right-justified store data
//   rdata, done, err    - extended load data, completion pulse, misaligned flag
//   stall               - pipeline freeze (combinational)
//   mem_en, mem_we      - memory request / write enable
//   mem_addr, mem_wdata - word address, full write word
//   mem_rdata, mem_ready- memory read word, request completes this cycle
module dm_access_ctrl
  import dm_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        dm_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  dm_state_e   state_q;
  dm_state_e   state_d;
  dm_size_e    size;
  logic        misaligned;
  logic        rmw;
  logic [31:0] load_val;
  logic [31:0] merged_w;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        err_q;

  assign size       = dm_size(dm_type);
  assign misaligned = dm_misaligned(size, addr[1:0]);
  assign rmw        = we & (size != SZ_WORD);

  dm_access_ctrl_lane_mux u_lane_mux (
    .word     (mem_rdata),
    .addr_lo  (addr[1:0]),
    .dm_type  (dm_type),
    .wdata    (wdata),
    .load_val (load_val),
    .merged   (merged_w)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (misaligned) state_d = ST_RESP;
          else if (rmw)   state_d = ST_RMW_RD;
          else            state_d = ST_ACC;
        end
      end
      ST_ACC:    if (mem_ready) state_d = ST_RESP;
      ST_RMW_RD: if (mem_ready) state_d = ST_RMW_WR;
      ST_RMW_WR: if (mem_ready) state_d = ST_RESP;
      // req is ignored here: the MEM stage advances at the end of RESP.
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = wdata;
    done      = 1'b0;
    case (state_q)
      ST_ACC: begin
        mem_en = 1'b1;
        mem_we = we;
      end
      ST_RMW_RD: begin
        mem_en = 1'b1;
      end
      ST_RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merged_q;
      end
      ST_RESP: done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = addr[ADDR_W-1:2];
  assign stall    = req & (state_q != ST_RESP) & ~rst;

  // Response registers: err is re-evaluated on every accepted request and
  // rdata only on a completed load, so both hold across stores and idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req)
        err_q <= misaligned;
      if (state_q == ST_ACC && mem_ready && !we)
        rdata_q <= load_val;
    end
  end

  // Merged store word, only consumed in RMW_WR after being written here.
  always_ff @(posedge clk) begin
    if (state_q == ST_RMW_RD && mem_ready)
      merged_q <= merged_w;
  end

  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
